// File: rtl/ac_unit_drain_controller.sv
// Bus-master sequencer: enables the audio capture unit, drains its PCM buffer
// into memory two 16-bit samples per 32-bit word, then disables the unit.
module ac_unit_drain_controller #(
  parameter logic [2:0] CONFIG_ADDR = 3'd0,
  parameter logic [2:0] STATUS_ADDR = 3'd1,
  parameter int         EMPTY_BIT   = 0,
  parameter logic [2:0] BUFFER_ADDR = 3'd2,
  parameter int         ADDR_WIDTH  = 32,
  parameter int         LEN_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [31:0]           config_i,
  input  logic [ADDR_WIDTH-1:0] base_address_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [LEN_WIDTH-1:0]  samples_o,
  input  logic                  irq_i,
  output logic                  cu_write_o,
  output logic [2:0]            cu_write_address_o,
  output logic [31:0]           cu_write_data_o,
  output logic [3:0]            cu_write_strobe_o,
  input  logic                  cu_write_done_i,
  input  logic                  cu_write_error_i,
  output logic                  cu_read_o,
  output logic [2:0]            cu_read_address_o,
  input  logic [31:0]           cu_read_data_i,
  input  logic                  cu_read_done_i,
  input  logic                  cu_read_error_i,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [31:0]           mem_data_o,
  input  logic                  mem_done_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENABLE, S_WAIT_IRQ, S_POLL, S_FETCH, S_STORE, S_DISABLE
  } state_t;

  state_t                state_r, state_n;
  logic [31:0]           cfg_r, cfg_n;
  logic [ADDR_WIDTH-1:0] base_r, base_n;
  logic [LEN_WIDTH-1:0]  len_r, len_n;
  logic [LEN_WIDTH-1:0]  samples_r, samples_n, samples_inc_s;
  logic [LEN_WIDTH-1:0]  word_idx_r, word_idx_n;
  logic [31:0]           pack_r, pack_n;
  logic                  stop_r, stop_n, error_n, done_n, stop_seen_s;
  logic                  cu_write_n, cu_read_n, mem_write_n;
  logic [2:0]            cu_write_address_n, cu_read_address_n;
  logic [31:0]           cu_write_data_n, mem_data_n;
  logic [ADDR_WIDTH-1:0] mem_address_n;
  logic                  rd_data_unused_s;

  assign stop_seen_s      = stop_r | stop_i;
  assign samples_inc_s    = samples_r + LEN_WIDTH'(1);
  assign rd_data_unused_s = ^cu_read_data_i[31:16];

  // Next-state and next-register values; outputs are derived from the next state.
  always_comb begin
    state_n    = state_r;
    cfg_n      = cfg_r;
    base_n     = base_r;
    len_n      = len_r;
    samples_n  = samples_r;
    word_idx_n = word_idx_r;
    pack_n     = pack_r;
    stop_n     = stop_seen_s;
    error_n    = error_o;
    done_n     = 1'b0;
    case (state_r)
      S_IDLE: begin
        stop_n = 1'b0;
        if (start_i) begin
          if (length_i == '0) begin
            error_n = 1'b1;
          end else begin
            error_n    = 1'b0;
            cfg_n      = config_i;
            base_n     = base_address_i;
            len_n      = length_i;
            samples_n  = '0;
            word_idx_n = '0;
            pack_n     = 32'h0000_0000;
            state_n    = S_ENABLE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ENABLE: begin
        if (cu_write_error_i) begin
          error_n = 1'b1;
          state_n = S_DISABLE;
        end else if (cu_write_done_i) begin
          state_n = S_WAIT_IRQ;
        end else begin
          state_n = S_ENABLE;
        end
      end
      S_WAIT_IRQ: begin
        // A half-filled pack register must reach memory before shutting down.
        if (stop_seen_s) begin
          state_n = samples_r[0] ? S_STORE : S_DISABLE;
        end else if (irq_i) begin
          state_n = S_POLL;
        end else begin
          state_n = S_WAIT_IRQ;
        end
      end
      S_POLL: begin
        if (cu_read_error_i) begin
          error_n = 1'b1;
          state_n = S_DISABLE;
        end else if (cu_read_done_i) begin
          state_n = cu_read_data_i[EMPTY_BIT] ? S_WAIT_IRQ : S_FETCH;
        end else begin
          state_n = S_POLL;
        end
      end
      S_FETCH: begin
        if (cu_read_error_i) begin
          error_n = 1'b1;
          state_n = S_DISABLE;
        end else if (cu_read_done_i) begin
          samples_n = samples_inc_s;
          if (!samples_r[0]) begin
            pack_n  = {16'h0000, cu_read_data_i[15:0]};
            state_n = ((samples_inc_s == len_r) || stop_seen_s) ? S_STORE : S_POLL;
          end else begin
            pack_n  = {cu_read_data_i[15:0], pack_r[15:0]};
            state_n = S_STORE;
          end
        end else begin
          state_n = S_FETCH;
        end
      end
      S_STORE: begin
        if (mem_done_i) begin
          word_idx_n = word_idx_r + LEN_WIDTH'(1);
          state_n    = ((samples_r == len_r) || stop_seen_s) ? S_DISABLE : S_POLL;
        end else begin
          state_n = S_STORE;
        end
      end
      S_DISABLE: begin
        if (cu_write_error_i) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else if (cu_write_done_i) begin
          done_n  = ~error_o;
          state_n = S_IDLE;
        end else begin
          state_n = S_DISABLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    cu_write_n         = 1'b0;
    cu_write_address_n = 3'd0;
    cu_write_data_n    = 32'h0000_0000;
    cu_read_n          = 1'b0;
    cu_read_address_n  = 3'd0;
    mem_write_n        = 1'b0;
    mem_address_n      = '0;
    mem_data_n         = 32'h0000_0000;
    case (state_n)
      S_ENABLE: begin
        cu_write_n         = 1'b1;
        cu_write_address_n = CONFIG_ADDR;
        cu_write_data_n    = cfg_n | 32'h0000_0001;
      end
      S_DISABLE: begin
        cu_write_n         = 1'b1;
        cu_write_address_n = CONFIG_ADDR;
        cu_write_data_n    = cfg_n & 32'hFFFF_FFFE;
      end
      S_POLL: begin
        cu_read_n         = 1'b1;
        cu_read_address_n = STATUS_ADDR;
      end
      S_FETCH: begin
        cu_read_n         = 1'b1;
        cu_read_address_n = BUFFER_ADDR;
      end
      S_STORE: begin
        mem_write_n   = 1'b1;
        mem_address_n = base_n + (ADDR_WIDTH'(word_idx_n) << 2);
        mem_data_n    = pack_n;
      end
      default: begin
        cu_write_n = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r            <= S_IDLE;
      cfg_r              <= 32'h0000_0000;
      base_r             <= '0;
      len_r              <= '0;
      samples_r          <= '0;
      word_idx_r         <= '0;
      pack_r             <= 32'h0000_0000;
      stop_r             <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      error_o            <= 1'b0;
      samples_o          <= '0;
      cu_write_o         <= 1'b0;
      cu_write_address_o <= 3'd0;
      cu_write_data_o    <= 32'h0000_0000;
      cu_write_strobe_o  <= 4'h0;
      cu_read_o          <= 1'b0;
      cu_read_address_o  <= 3'd0;
      mem_write_o        <= 1'b0;
      mem_address_o      <= '0;
      mem_data_o         <= 32'h0000_0000;
    end else begin
      state_r            <= state_n;
      cfg_r              <= cfg_n;
      base_r             <= base_n;
      len_r              <= len_n;
      samples_r          <= samples_n;
      word_idx_r         <= word_idx_n;
      pack_r             <= pack_n;
      stop_r             <= stop_n;
      busy_o             <= (state_n != S_IDLE);
      done_o             <= done_n;
      error_o            <= error_n;
      samples_o          <= samples_n;
      cu_write_o         <= cu_write_n;
      cu_write_address_o <= cu_write_address_n;
      cu_write_data_o    <= cu_write_data_n;
      cu_write_strobe_o  <= cu_write_n ? 4'hF : 4'h0;
      cu_read_o          <= cu_read_n;
      cu_read_address_o  <= cu_read_address_n;
      mem_write_o        <= mem_write_n;
      mem_address_o      <= mem_address_n;
      mem_data_o         <= mem_data_n;
    end
  end

endmodule

// File: tb/tb_ac_unit_drain_controller.sv
// Directed bench: a cycle-level capture-unit/memory responder plus a vector table
// of complete drain runs and hand-written corner-case sequences.
module tb_ac_unit_drain_controller;

  logic        clk = 1'b0;
  logic        rst_n, start_i, stop_i, irq_i;
  logic [31:0] config_i, base_address_i;
  logic [15:0] length_i;
  logic        busy_o, done_o, error_o;
  logic [15:0] samples_o;
  logic        cu_write_o, cu_write_done, cu_write_error;
  logic [2:0]  cu_write_address_o, cu_read_address_o;
  logic [31:0] cu_write_data_o, cu_read_data, mem_address_o, mem_data_o;
  logic [3:0]  cu_write_strobe_o;
  logic        cu_read_o, cu_read_done, cu_read_error;
  logic        mem_write_o, mem_done;

  always #5 clk = ~clk;

  ac_unit_drain_controller dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stop_i(stop_i),
    .config_i(config_i), .base_address_i(base_address_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .samples_o(samples_o),
    .irq_i(irq_i),
    .cu_write_o(cu_write_o), .cu_write_address_o(cu_write_address_o),
    .cu_write_data_o(cu_write_data_o), .cu_write_strobe_o(cu_write_strobe_o),
    .cu_write_done_i(cu_write_done), .cu_write_error_i(cu_write_error),
    .cu_read_o(cu_read_o), .cu_read_address_o(cu_read_address_o),
    .cu_read_data_i(cu_read_data), .cu_read_done_i(cu_read_done),
    .cu_read_error_i(cu_read_error),
    .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_done_i(mem_done)
  );

  typedef struct {
    logic [15:0] len;
    logic [31:0] base;
    logic [31:0] cfg;
    int          nw;
    logic [31:0] a0, d0, a1, d1;
  } vec_t;

  vec_t        vecs [4];
  int          n_cmp = 0, n_fail = 0;
  logic [15:0] samp [8];
  int          avail, rd_ptr, fetch_cnt, err_fetch, empty_reads, n_wr, n_mem, done_cnt;
  logic [31:0] wr_log [8];
  logic [31:0] mem_a [8];
  logic [31:0] mem_d [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_model(input int a);
    avail = a; rd_ptr = 0; fetch_cnt = 0; err_fetch = 0; empty_reads = 0;
    n_wr = 0; n_mem = 0; done_cnt = 0;
    cu_write_done = 1'b0; cu_write_error = 1'b0;
    cu_read_done = 1'b0; cu_read_error = 1'b0; cu_read_data = 32'h0;
    mem_done = 1'b0;
    irq_i = (avail > 0);
  endtask

  // One cycle of the capture unit and memory: answer requests one cycle after they appear.
  task automatic tick();
    @(negedge clk);
    if (done_o) done_cnt++;
    if (cu_write_done || cu_write_error) begin
      cu_write_done = 1'b0; cu_write_error = 1'b0;
    end else if (cu_write_o) begin
      check("wr_addr_strobe", {25'd0, cu_write_address_o, cu_write_strobe_o}, {25'd0, 3'd0, 4'hF});
      if (n_wr < 8) wr_log[n_wr] = cu_write_data_o;
      n_wr++;
      cu_write_done = 1'b1;
    end
    if (cu_read_done || cu_read_error) begin
      cu_read_done = 1'b0; cu_read_error = 1'b0;
    end else if (cu_read_o) begin
      if (cu_read_address_o == 3'd1) begin
        cu_read_data = {31'd0, (avail <= 0)};
        if (avail <= 0) empty_reads++;
        cu_read_done = 1'b1;
      end else if (cu_read_address_o == 3'd2) begin
        fetch_cnt++;
        if (fetch_cnt == err_fetch) begin
          cu_read_error = 1'b1;
        end else begin
          cu_read_data = {16'hDEAD, samp[rd_ptr[2:0]]};
          rd_ptr++; avail--;
          cu_read_done = 1'b1;
        end
      end else begin
        cu_read_data = 32'h0;
        cu_read_done = 1'b1;
      end
    end
    if (mem_done) begin
      mem_done = 1'b0;
    end else if (mem_write_o) begin
      if (n_mem < 8) begin mem_a[n_mem] = mem_address_o; mem_d[n_mem] = mem_data_o; end
      n_mem++;
      mem_done = 1'b1;
    end
    irq_i = (avail > 0);
  endtask

  task automatic do_start(input logic [15:0] len, input logic [31:0] base, input logic [31:0] cfg);
    length_i = len; base_address_i = base; config_i = cfg;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (!busy_o) break;
      tick();
    end
    check({tag, ".timeout"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_run(input string tag, input logic [31:0] cfg, input int nw,
                           input logic [31:0] a0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] d1,
                           input int exp_samp, input int exp_done, input int exp_err);
    check({tag, ".n_cfg_writes"}, n_wr, 2);
    check({tag, ".enable_data"}, wr_log[0], cfg | 32'h1);
    check({tag, ".disable_data"}, wr_log[1], cfg & 32'hFFFF_FFFE);
    check({tag, ".n_mem_writes"}, n_mem, nw);
    if (nw > 0) begin
      check({tag, ".addr0"}, mem_a[0], a0);
      check({tag, ".data0"}, mem_d[0], d0);
    end
    if (nw > 1) begin
      check({tag, ".addr1"}, mem_a[1], a1);
      check({tag, ".data1"}, mem_d[1], d1);
    end
    check({tag, ".samples"}, {16'd0, samples_o}, exp_samp);
    check({tag, ".done_pulses"}, done_cnt, exp_done);
    check({tag, ".error"}, {31'd0, error_o}, exp_err);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) samp[i] = 16'((i + 1) * 16'h11);
    vecs[0] = '{16'd4, 32'h0000_1000, 32'h0000_0320, 2, 32'h0000_1000, 32'h0022_0011, 32'h0000_1004, 32'h0044_0033};
    vecs[1] = '{16'd3, 32'h0000_1000, 32'h0000_0320, 2, 32'h0000_1000, 32'h0022_0011, 32'h0000_1004, 32'h0000_0033};
    vecs[2] = '{16'd1, 32'h0000_2000, 32'hFFFF_FFFF, 1, 32'h0000_2000, 32'h0000_0011, 32'h0, 32'h0};
    vecs[3] = '{16'd4, 32'hFFFF_FFFC, 32'h0000_0000, 2, 32'hFFFF_FFFC, 32'h0022_0011, 32'h0000_0000, 32'h0044_0033};

    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    config_i = 32'h0; base_address_i = 32'h0; length_i = 16'd0;
    reset_model(0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, error_o, cu_write_o, cu_read_o, mem_write_o, samples_o, cu_write_strobe_o},
          32'd0);
    check("reset_wdata", cu_write_data_o, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      reset_model(int'(vecs[v].len));
      do_start(vecs[v].len, vecs[v].base, vecs[v].cfg);
      check($sformatf("vec%0d.busy", v), {31'd0, busy_o}, 32'd1);
      run_to_idle($sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].nw, vecs[v].a0, vecs[v].d0,
                vecs[v].a1, vecs[v].d1, int'(vecs[v].len), 1, 0);
      tick();
    end

    // Buffer runs dry after one sample; data arrives again 20 cycles later.
    reset_model(1);
    do_start(16'd4, 32'h1000, 32'h320);
    for (int i = 0; i < 300 && empty_reads == 0; i++) tick();
    check("s3.empty_seen", {31'd0, (empty_reads > 0)}, 32'd1);
    repeat (20) tick();
    check("s3.paused_busy", {31'd0, busy_o}, 32'd1);
    check("s3.paused_no_mem", n_mem, 0);
    avail = 3; irq_i = 1'b1;
    run_to_idle("s3");
    check_run("s3", 32'h320, 2, 32'h1000, 32'h0022_0011, 32'h1004, 32'h0044_0033, 4, 1, 0);
    tick();

    // Stop requested while the first sample is being returned.
    reset_model(8);
    do_start(16'd8, 32'h1000, 32'h320);
    for (int i = 0; i < 300 && fetch_cnt < 1; i++) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    run_to_idle("s4");
    check_run("s4", 32'h320, 1, 32'h1000, 32'h0000_0011, 32'h0, 32'h0, 1, 1, 0);
    tick();

    // Zero length is rejected without leaving IDLE.
    reset_model(4);
    do_start(16'd0, 32'h1000, 32'h320);
    check("len0.error", {31'd0, error_o}, 32'd1);
    check("len0.busy", {31'd0, busy_o}, 32'd0);
    tick();
    check("len0.no_write", n_wr, 0);

    // Read error on the second fetch.
    reset_model(4);
    err_fetch = 2;
    do_start(16'd4, 32'h1000, 32'h320);
    run_to_idle("s5");
    check_run("s5", 32'h320, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    tick();
    reset_model(4);
    do_start(16'd4, 32'h1000, 32'h320);
    check("s5.error_cleared", {31'd0, error_o}, 32'd0);
    run_to_idle("s5b");
    check_run("s5b", 32'h320, 2, 32'h1000, 32'h0022_0011, 32'h1004, 32'h0044_0033, 4, 1, 0);
    tick();

    // Asynchronous reset during STORE, then a clean rerun with a start pulse while busy.
    reset_model(4);
    do_start(16'd4, 32'h1000, 32'h320);
    for (int i = 0; i < 300 && !mem_write_o; i++) tick();
    check("s6.in_store", {31'd0, mem_write_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("s6.async_reset", {busy_o, done_o, error_o, cu_write_o, cu_read_o, mem_write_o, samples_o, cu_write_strobe_o},
          32'd0);
    check("s6.async_addr", mem_address_o | mem_data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model(4);
    tick();
    do_start(16'd4, 32'h1000, 32'h320);
    repeat (5) tick();
    length_i = 16'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_to_idle("s6");
    check_run("s6", 32'h320, 2, 32'h1000, 32'h0022_0011, 32'h1004, 32'h0044_0033, 4, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
